rx_lane_deskew: RTL



---
 rtl/rx_lane_deskew.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/rx_lane_deskew.sv
// rx_lane_deskew: buffers each active lane in a small FIFO and releases lane-aligned words once all lanes agree on COM.
// Optional saturating failure counter is built when RX_DESKEW_STATS_EN is defined.
module rx_lane_deskew #(
    parameter int unsigned LANES    = 16,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned MAX_SKEW = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [LANES-1:0]   inValid,
    input  logic [8*LANES-1:0] inData,
    input  logic [LANES-1:0]   inDataK,
    input  logic [4:0]         numberOfDetectedLanes,
    output logic               outValid,
    output logic [8*LANES-1:0] outData,
    output logic [LANES-1:0]   outDataK,
    output logic               deskewed,
    output logic               skewError,
    output logic [7:0]         skewErrorCount
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned CW = $clog2(MAX_SKEW + 2);
    localparam logic [8:0]  COM = 9'h1BC;

    typedef enum logic [1:0] {IDLE, SEARCH, ALIGNED} state_t;
    state_t state, nextState;

    logic [8:0]    mem   [LANES][DEPTH];
    logic [PW-1:0] wrPtr [LANES];
    logic [PW-1:0] rdPtr [LANES];
    logic [8:0]    head  [LANES];
    logic [4:0]    prevLanes;
    logic          skewRun;
    logic [CW-1:0] skewCnt;
    logic [CW-1:0] curCnt;

    logic [LANES-1:0] active, empty, full, headIsCom, holdCom, wrEn, pop;
    logic laneOk, overflowAny, laneChange, allNonEmpty, allCom, anyCom;
    logic allComAligned, anyComAligned, skewStart, timeout;
    logic flush, err, nextValid;
    logic [8*LANES-1:0] nextData;
    logic [LANES-1:0]   nextK;

    // Per-lane FIFO status and COM detection at the head
    always_comb begin
        for (int unsigned i = 0; i < LANES; i++) begin
            active[i]    = i < 32'(numberOfDetectedLanes);
            empty[i]     = wrPtr[i] == rdPtr[i];
            full[i]      = (wrPtr[i][AW] != rdPtr[i][AW]) && (wrPtr[i][AW-1:0] == rdPtr[i][AW-1:0]);
            head[i]      = mem[i][rdPtr[i][AW-1:0]];
            headIsCom[i] = head[i] == COM;
            holdCom[i]   = active[i] && !empty[i] && headIsCom[i];
            wrEn[i]      = active[i] && inValid[i] && !full[i];
        end
    end

    assign laneOk        = (numberOfDetectedLanes != 5'd0) && (32'(numberOfDetectedLanes) <= LANES);
    assign overflowAny   = |(active & inValid & full);
    assign laneChange    = numberOfDetectedLanes != prevLanes;
    assign allNonEmpty   = &(~active | ~empty);
    assign allCom        = &(~active | holdCom);
    assign anyCom        = |holdCom;
    assign allComAligned = &(~active | headIsCom);
    assign anyComAligned = |(active & headIsCom);
    assign skewStart     = skewRun || anyCom;
    assign curCnt        = skewRun ? skewCnt : '0;
    assign timeout       = skewStart && !allCom && (curCnt > CW'(MAX_SKEW));

    // State register, lane-count history and skew window counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            prevLanes <= '0;
            skewRun   <= 1'b0;
            skewCnt   <= '0;
        end else begin
            state     <= nextState;
            prevLanes <= numberOfDetectedLanes;
            if (flush || state != SEARCH || nextState != SEARCH) begin
                skewRun <= 1'b0;
                skewCnt <= '0;
            end else if (skewStart) begin
                skewRun <= 1'b1;
                skewCnt <= (curCnt == CW'(MAX_SKEW + 1)) ? curCnt : curCnt + CW'(1);
            end
        end
    end

    // Next state, flush and error, in event priority order
    always_comb begin
        nextState = state;
        flush     = 1'b0;
        err       = 1'b0;
        if (!laneOk) begin
            nextState = IDLE;
            flush     = 1'b1;
        end else if (state == IDLE) begin
            nextState = SEARCH;
            flush     = 1'b1;
        end else if (overflowAny) begin
            nextState = SEARCH;
            flush     = 1'b1;
            err       = 1'b1;
        end else if (laneChange) begin
            nextState = SEARCH;
            flush     = 1'b1;
        end else begin
            case (state)
                SEARCH: begin
                    if (allCom) begin
                        nextState = ALIGNED;
                    end else if (timeout) begin
                        flush = 1'b1;
                        err   = 1'b1;
                    end
                end
                ALIGNED: begin
                    if (allNonEmpty && anyComAligned && !allComAligned) begin
                        nextState = SEARCH;
                        flush     = 1'b1;
                        err       = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Pop selection and the next output word
    always_comb begin
        pop       = '0;
        nextValid = 1'b0;
        nextData  = '0;
        nextK     = '0;
        if (!flush) begin
            case (state)
                SEARCH: begin
                    pop       = allCom ? active : (active & ~empty & ~headIsCom);
                    nextValid = allCom;
                end
                ALIGNED: begin
                    pop       = allNonEmpty ? active : '0;
                    nextValid = allNonEmpty;
                end
                default: ;
            endcase
        end
        for (int unsigned i = 0; i < LANES; i++) begin
            if (nextValid && active[i]) begin
                nextData[8*i +: 8] = head[i][7:0];
                nextK[i]           = head[i][8];
            end
        end
    end

    // FIFO pointers; a flush also drops the symbol written in that cycle
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < LANES; i++) begin
            if (reset || flush) begin
                wrPtr[i] <= '0;
                rdPtr[i] <= '0;
            end else begin
                if (wrEn[i]) wrPtr[i] <= wrPtr[i] + PW'(1);
                if (pop[i])  rdPtr[i] <= rdPtr[i] + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < LANES; i++) begin
            if (wrEn[i]) mem[i][wrPtr[i][AW-1:0]] <= {inDataK[i], inData[8*i +: 8]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            outValid  <= 1'b0;
            outData   <= '0;
            outDataK  <= '0;
            deskewed  <= 1'b0;
            skewError <= 1'b0;
        end else begin
            outValid  <= nextValid;
            outData   <= nextData;
            outDataK  <= nextK;
            deskewed  <= nextState == ALIGNED;
            skewError <= err;
        end
    end

`ifdef RX_DESKEW_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            skewErrorCount <= 8'h00;
        end else if (err && skewErrorCount != 8'hFF) begin
            skewErrorCount <= skewErrorCount + 8'd1;
        end
    end
`else
    assign skewErrorCount = 8'h00;
`endif

endmodule
